// File: rtl/jam_pkg.sv
// Shared widths, defaults and state encoding for the cost-table burst arbiter.
package jam_pkg;

  localparam int unsigned LIST_COUNT_DFLT = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned COST_W = 7;
  localparam int unsigned SUM_W  = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } jam_state_e;

endpackage

// File: rtl/jam_rr_pick.sv
// Two-way round-robin pick: a lone requester wins; on contention the one
// that did not win last time is chosen.
module jam_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic any,
  output logic winner
);

  always_comb begin
    any    = req0 | req1;
    winner = (req0 & req1) ? ~rr_last : req1;
  end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Grants whole bursts of cost-table lookups (workers 0..LIST_COUNT-1) to one of
// two permutation evaluators, returning per-beat costs and the burst total.
//
// state | meaning
// IDLE  | no burst in flight, table port parked at W=0/J=0
// BURST | owner drives one job per cycle, cnt walks the worker index
module jam_cost_arbiter
  import jam_pkg::*;
#(
  parameter int unsigned LIST_COUNT = LIST_COUNT_DFLT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req0,
  input  logic [IDX_W-1:0]  job0,
  output logic              ack0,
  input  logic              req1,
  input  logic [IDX_W-1:0]  job1,
  output logic              ack1,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic              rsp_valid,
  output logic [COST_W-1:0] rsp_cost,
  output logic              rsp_id,
  output logic              rsp_done,
  output logic [SUM_W-1:0]  rsp_sum
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIST_COUNT - 1);

  jam_state_e       state;
  logic [IDX_W-1:0] cnt;
  logic             owner;
  logic             rr_last;
  logic [SUM_W-1:0] acc;

  logic             any;
  logic             winner;
  logic [SUM_W-1:0] cost_ext;

  jam_rr_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .rr_last (rr_last),
    .any     (any),
    .winner  (winner)
  );

  assign cost_ext = SUM_W'(Cost);

  always_comb begin
    W    = '0;
    J    = '0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    if (state == BURST) begin
      W    = cnt;
      J    = owner ? job1 : job0;
      ack0 = ~owner;
      ack1 = owner;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      rr_last   <= 1'b1;
      acc       <= '0;
      rsp_valid <= 1'b0;
      rsp_cost  <= '0;
      rsp_id    <= 1'b0;
      rsp_done  <= 1'b0;
      rsp_sum   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            state   <= BURST;
            owner   <= winner;
            rr_last <= winner;
            cnt     <= '0;
            acc     <= '0;
          end
        end
        BURST: begin
          rsp_cost  <= Cost;
          rsp_valid <= 1'b1;
          rsp_id    <= owner;
          acc       <= acc + cost_ext;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            rsp_done <= 1'b1;
            rsp_sum  <= acc + cost_ext;
            // rr_last already equals the finishing owner, so a waiting peer wins next
            if (any) begin
              owner   <= winner;
              rr_last <= winner;
              cnt     <= '0;
              acc     <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jam_cost_arbiter.md
Name: jam_cost_arbiter

Overview:
- Shares the single worker/job cost-table lookup port (W, J -> Cost) between two permutation evaluators.
- Each requester wins a whole burst of LIST_COUNT lookups: workers 0..LIST_COUNT-1 for one candidate assignment.
- The block returns each per-lookup cost and the burst total, tagged with the requester id.
- Bursts are arbitrated round-robin, so two evaluators can search disjoint permutation ranges in parallel over one cost table.

Parameters:
- LIST_COUNT, 8, lookups per burst (number of workers/jobs). Legal range 2..8; larger values overflow the 10-bit sum.

Ports:
- CLK  in  1  clock, rising-edge.
- RST_N  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 burst request; level signal.
- job0  in  3  requester 0 job for the worker currently shown on W.
- ack0  out  1  job0 consumed this cycle for worker W.
- req1  in  1  requester 1 burst request; level signal.
- job1  in  3  requester 1 job for the worker currently shown on W.
- ack1  out  1  job1 consumed this cycle for worker W.
- W  out  3  worker index to the cost table.
- J  out  3  job index to the cost table.
- Cost  in  7  cost-table data; combinational from W/J, same cycle.
- rsp_valid  out  1  rsp_cost valid, one per beat.
- rsp_cost  out  7  registered cost of the previous beat.
- rsp_id  out  1  owner of the burst that produced the current rsp_* values.
- rsp_done  out  1  1-cycle pulse; rsp_sum is final.
- rsp_sum  out  10  burst cost total.

Behaviour:
- Reset (RST_N=0, async): state=IDLE, cnt=0, owner=0, rr_last=1 (so requester 0 wins first). rsp_valid=0, rsp_cost=0, rsp_id=0, rsp_done=0, rsp_sum=0.
- Reset asserted mid-burst: the burst is abandoned, no rsp_done is issued, and the requester must re-request.
- States:
  - IDLE: W=0, J=0, ack0=ack1=0.
  - IDLE -> BURST on any req. Winner: the only requester asserting req, or, if both assert, the one not equal to rr_last.
  - On entry: owner <= winner, rr_last <= winner, cnt <= 0, sum accumulator cleared.
- BURST, every cycle:
  - W=cnt, J=job_owner, ack_owner=1, ack_other=0.
  - At the clock edge: rsp_cost<=Cost, rsp_valid<=1, rsp_id<=owner, acc<=acc+Cost (zero-extended to 10 bits), cnt<=cnt+1.
- Last beat (cnt==LIST_COUNT-1):
  - Next cycle: rsp_done=1 and rsp_sum = acc + last Cost.
  - Arbitration happens in the same cycle as the last beat, using the updated rr_last.
  - If any req is high, go directly to BURST for the winner: cnt=0, accumulator restarts at 0, no idle bubble.
  - Otherwise go to IDLE.
- rsp_valid and rsp_done are low in every other cycle. rsp_sum holds its value until the next rsp_done.
- req is sampled only at arbitration points. Deasserting req mid-burst does not shorten the burst; the owner must keep driving job for all LIST_COUNT acks.
- Latency: rsp_cost for worker k appears exactly 1 cycle after the ack beat for k. rsp_done appears 1 cycle after the last ack.
- Fairness: with both requesters continuously active, bursts strictly alternate 0,1,0,1...
- Sum width: LIST_COUNT*127 <= 1016 fits in 10 bits, so no saturation logic is needed.
- W and J are combinational from registered cnt/owner and the requester job input. The owner's job must be stable within the cycle.

Decomposition:
- Package jam_pkg holds:
  - LIST_COUNT default.
  - Widths IDX_W=3, COST_W=7, SUM_W=10.
  - State enum {IDLE, BURST}.
- One sub-module: jam_rr_pick, a combinational 2-way round-robin pick. Inputs: req0, req1, rr_last. Outputs: any, winner. It is reused by future N-evaluator variants.

Test Plan:
- Cost model = 10*W+J. req0 alone with jobs 0..7 (job0=W) -> ack0 for 8 consecutive cycles; rsp_cost 0,11,22,...,77 with rsp_id=0; rsp_done with rsp_sum=308; return to IDLE.
- req0 and req1 asserted together after reset, job1=7 constant -> requester 0 served first (sum 308), then requester 1 with no bubble: rsp_sum=336, rsp_id=1.
- Both reqs held for 4 bursts -> owner sequence 0,1,0,1; exactly 32 back-to-back ack cycles; 4 rsp_done pulses.
- req1 dropped after its 3rd ack -> burst still runs 8 beats; rsp_done issued; then IDLE if req0 is low.
- RST_N pulsed low at beat 4 -> all outputs 0 immediately; no rsp_done. Then req1 alone -> requester 0 not preferred; requester 1 served with a full 8-beat burst.
- All Cost=127 -> rsp_sum=1016, no wrap.
